issue_queue_free_index_list: RTL and testbench

- Index supplier for the issue queue. It holds the free IQ entry indices in a circular buffer.
- On the pop side it hands out up to POP_WIDTH indices per cycle to the rename/dispatch allocator.
- On the push side it takes back up to PUSH_WIDTH sparse released indices per cycle, from the wakeup/select release and from post-recovery return.
- It owns the reset-to-full initialisation sequence. Callers gate allocation on `ready` and `count`.

---
 rtl/issue_queue_free_index_list_if.sv | 26 ++
 rtl/issue_queue_free_index_list.sv | 128 ++++++++++++
 tb/tb_issue_queue_free_index_list.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_free_index_list_if.sv
// Allocation/release bundle between the issue-queue free index list and its callers.
interface issue_queue_free_index_list_if #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned POP_WIDTH   = 2,
  parameter int unsigned PUSH_WIDTH  = 4
);
  logic                              refill;
  logic [POP_WIDTH-1:0]              pop;
  logic [POP_WIDTH*INDEX_WIDTH-1:0]  poppedData;
  logic [PUSH_WIDTH-1:0]             push;
  logic [PUSH_WIDTH*INDEX_WIDTH-1:0] pushedData;
  logic [INDEX_WIDTH:0]              count;
  logic                              ready;
  logic                              underflow;
  logic                              overflow;

  modport master (
    output refill, pop, push, pushedData,
    input  poppedData, count, ready, underflow, overflow
  );

  modport slave (
    input  refill, pop, push, pushedData,
    output poppedData, count, ready, underflow, overflow
  );
endinterface

// File: rtl/issue_queue_free_index_list.sv
// Circular free list of issue-queue indices: multi-port pop/push, self-initialising to 0..SIZE-1.
module issue_queue_free_index_list #(
  parameter int unsigned SIZE           = 16,
  parameter int unsigned INDEX_WIDTH    = 4,
  parameter int unsigned POP_WIDTH      = 2,
  parameter int unsigned PUSH_WIDTH     = 4,
  parameter int unsigned INIT_PER_CYCLE = 4
) (
  input logic clk,
  input logic rst,
  issue_queue_free_index_list_if.slave bus
);
  localparam int unsigned CW          = INDEX_WIDTH + 1;
  localparam int unsigned RW          = CW + 2;
  localparam int unsigned INIT_CYCLES = SIZE / INIT_PER_CYCLE;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] mem [SIZE];
  logic [INDEX_WIDTH-1:0] head, tail;
  logic [INDEX_WIDTH-1:0] init_cnt;
  logic [INDEX_WIDTH-1:0] init_base;
  logic [CW-1:0]          count;
  logic                   underflow, overflow;
  logic                   init_last;
  logic [POP_WIDTH-1:0]   pop_grant;
  logic [PUSH_WIDTH-1:0]  push_accept;
  logic [INDEX_WIDTH-1:0] push_addr [PUSH_WIDTH];
  logic [RW-1:0]          pop_n, push_n;

  assign init_last = (state == INIT) && (init_cnt == INDEX_WIDTH'(INIT_CYCLES - 1));
  assign init_base = INDEX_WIDTH'(init_cnt * INDEX_WIDTH'(INIT_PER_CYCLE));

  always_comb begin
    state_next = state;
    if (bus.refill)     state_next = INIT;
    else if (init_last) state_next = READY;
  end

  // Ranks count requested bits (not grants); push room is judged after this cycle's pops.
  always_comb begin
    logic [RW-1:0] seen;
    logic [RW-1:0] base;
    seen           = '0;
    base           = '0;
    pop_n          = '0;
    pop_grant      = '0;
    bus.poppedData = '0;
    for (int unsigned i = 0; i < POP_WIDTH; i++) begin
      if (state == READY)
        bus.poppedData[i*INDEX_WIDTH +: INDEX_WIDTH] = mem[head + INDEX_WIDTH'(seen)];
      if (bus.pop[i]) begin
        if ((state == READY) && (seen < RW'(count))) begin
          pop_grant[i] = 1'b1;
          pop_n        = pop_n + RW'(1);
        end
        seen = seen + RW'(1);
      end
    end
    base        = RW'(count) - pop_n;
    seen        = '0;
    push_n      = '0;
    push_accept = '0;
    for (int unsigned j = 0; j < PUSH_WIDTH; j++) begin
      push_addr[j] = tail + INDEX_WIDTH'(seen);
      if (bus.push[j]) begin
        if ((state == READY) && ((base + seen) < RW'(SIZE))) begin
          push_accept[j] = 1'b1;
          push_n         = push_n + RW'(1);
        end
        seen = seen + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.refill) begin
        init_cnt <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else if (state == INIT) begin
        init_cnt <= init_cnt + INDEX_WIDTH'(1);
        if (init_last) begin
          init_cnt <= '0;
          head     <= '0;
          tail     <= '0;
          count    <= CW'(SIZE);
        end
      end else begin
        head  <= head + INDEX_WIDTH'(pop_n);
        tail  <= tail + INDEX_WIDTH'(push_n);
        count <= count - CW'(pop_n) + CW'(push_n);
        if (|(bus.pop & ~pop_grant))    underflow <= 1'b1;
        if (|(bus.push & ~push_accept)) overflow  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.refill) begin
      if (state == INIT) begin
        for (int unsigned k = 0; k < INIT_PER_CYCLE; k++)
          mem[init_base + INDEX_WIDTH'(k)] <= init_base + INDEX_WIDTH'(k);
      end else begin
        for (int unsigned j = 0; j < PUSH_WIDTH; j++)
          if (push_accept[j])
            mem[push_addr[j]] <= bus.pushedData[j*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
  end

  assign bus.count     = count;
  assign bus.ready     = (state == READY);
  assign bus.underflow = underflow;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_issue_queue_free_index_list.sv
// Randomised and directed bench for issue_queue_free_index_list against a queue-based model.
module tb_issue_queue_free_index_list;
  localparam int IW = 4;
  localparam int PW = 2;
  localparam int UW = 4;
  localparam int SZ = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_queue_free_index_list_if #(.INDEX_WIDTH(IW), .POP_WIDTH(PW), .PUSH_WIDTH(UW)) bus ();

  issue_queue_free_index_list #(
    .SIZE(SZ), .INDEX_WIDTH(IW), .POP_WIDTH(PW), .PUSH_WIDTH(UW), .INIT_PER_CYCLE(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model: free indices in grant order, plus init progress and sticky flags.
  int   q[$];
  bit   m_ready;
  int   m_init;
  bit   m_uf, m_of;
  logic [PW*IW-1:0] obs_pd, exp_pd, exp_mask;
  logic [PW-1:0]    exp_gnt;
  int   checks = 0;
  int   errors = 0;

  task automatic model_reset();
    q.delete();
    m_ready = 0;
    m_init  = 0;
    m_uf    = 0;
    m_of    = 0;
  endtask

  // Drive one cycle, capture poppedData before the edge, then advance the model past the edge.
  task automatic step(input logic [PW-1:0] p, input logic [UW-1:0] u,
                      input logic [UW*IW-1:0] d, input logic rf);
    int k;
    int n_pop;
    bus.pop = p; bus.push = u; bus.pushedData = d; bus.refill = rf;
    #2;
    obs_pd   = bus.poppedData;
    exp_pd   = '0;
    exp_mask = '1;
    exp_gnt  = '0;
    n_pop    = 0;
    if (m_ready) begin
      exp_mask = '0;
      k = 0;
      for (int i = 0; i < PW; i++) begin
        if (p[i]) begin
          if (k < q.size()) begin
            exp_gnt[i] = 1'b1;
            exp_mask[i*IW +: IW] = '1;
            exp_pd[i*IW +: IW]   = IW'(q[k]);
            n_pop++;
          end else if (!rf) m_uf = 1;
          k++;
        end
      end
    end
    @(posedge clk); #1;
    if (rf) begin
      q.delete(); m_ready = 0; m_init = 0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == SZ/4) begin
        m_ready = 1;
        for (int i = 0; i < SZ; i++) q.push_back(i);
      end
    end else begin
      repeat (n_pop) void'(q.pop_front());
      for (int j = 0; j < UW; j++)
        if (u[j]) begin
          if (q.size() < SZ) q.push_back(int'(d[j*IW +: IW]));
          else m_of = 1;
        end
    end
  endtask

  task automatic do_init();
    step('0, '0, '0, 1'b1);
    repeat (4) step('0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.refill = 0; bus.pop = '0; bus.push = '0; bus.pushedData = '0;
    model_reset();
    #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", bus.ready); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=00", bus.underflow, bus.overflow); end
    checks++; if (bus.poppedData !== '0) begin errors++; $display("FAIL reset_pd got=%0h exp=0", bus.poppedData); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_init();
    for (int c = 0; c < 4; c++) begin
      step(PW'($urandom), UW'($urandom), (UW*IW)'($urandom), 1'b0);
      checks++; if (obs_pd !== exp_pd) begin errors++; $display("FAIL init_pd c=%0d got=%0h exp=%0h", c, obs_pd, exp_pd); end
      checks++; if (bus.ready !== m_ready) begin errors++; $display("FAIL init_ready c=%0d got=%0b exp=%0b", c, bus.ready, m_ready); end
      checks++; if (bus.count !== 5'(q.size())) begin errors++; $display("FAIL init_count c=%0d got=%0d exp=%0d", c, bus.count, q.size()); end
      checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL init_flags c=%0d got=%0b%0b exp=00", c, bus.underflow, bus.overflow); end
    end
    checks++; if (bus.ready !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL init_done got ready=%0b count=%0d exp ready=1 count=16", bus.ready, bus.count); end
  endtask

  task automatic test_pop_pair();
    step(2'b11, '0, '0, 1'b0);
    checks++; if (obs_pd !== 8'h10) begin errors++; $display("FAIL pop_pair_pd got=%0h exp=10", obs_pd); end
    checks++; if (bus.count !== 5'd14) begin errors++; $display("FAIL pop_pair_count got=%0d exp=14", bus.count); end
  endtask

  task automatic test_sparse_pop_overflow();
    do_init();
    step(2'b10, '0, '0, 1'b0);
    checks++; if (obs_pd[7:4] !== 4'd0) begin errors++; $display("FAIL sparse_pop_pd got=%0d exp=0", obs_pd[7:4]); end
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL sparse_pop_count got=%0d exp=15", bus.count); end
    step('0, 4'b1010, {4'd3, 4'd0, 4'd7, 4'd0}, 1'b0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL push_full_count got=%0d exp=16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL push_full_overflow got=%0b exp=1", bus.overflow); end
  endtask

  task automatic test_underflow();
    for (int c = 0; c < 8; c++) begin
      step(2'b11, '0, '0, 1'b0);
      checks++; if ((obs_pd & exp_mask) !== exp_pd) begin errors++; $display("FAIL drain_pd c=%0d got=%0h exp=%0h", c, obs_pd & exp_mask, exp_pd); end
    end
    checks++; if (exp_pd !== 8'h7F) begin errors++; $display("FAIL drain_fifo_tail model=%0h exp=7f", exp_pd); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    step(2'b11, 4'b0101, {4'd0, 4'd12, 4'd0, 4'd5}, 1'b0);
    checks++; if (exp_gnt !== 2'b00 || bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_pop got underflow=%0b exp=1", bus.underflow); end
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL empty_push_count got=%0d exp=2", bus.count); end
    step(2'b11, '0, '0, 1'b0);
    checks++; if (obs_pd !== 8'hC5) begin errors++; $display("FAIL no_bypass_pd got=%0h exp=c5", obs_pd); end
  endtask

  task automatic test_wrap();
    logic [UW-1:0] u;
    int a, b;
    do_init();
    for (int c = 0; c < 20; c++) begin
      a = $urandom_range(0, UW-1);
      do b = $urandom_range(0, UW-1); while (b == a);
      u = '0; u[a] = 1'b1; u[b] = 1'b1;
      step(2'b11, u, (UW*IW)'($urandom), 1'b0);
      checks++; if ((obs_pd & exp_mask) !== exp_pd || exp_gnt !== 2'b11) begin errors++; $display("FAIL wrap_pd c=%0d got=%0h exp=%0h", c, obs_pd & exp_mask, exp_pd); end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL wrap_count c=%0d got=%0d exp=16", c, bus.count); end
    end
    checks++; if (bus.overflow !== m_of) begin errors++; $display("FAIL wrap_overflow got=%0b exp=%0b", bus.overflow, m_of); end
  endtask

  task automatic test_refill();
    do_init();
    repeat (3) step(2'b11, '0, '0, 1'b0);
    step(2'b01, '0, '0, 1'b0);
    checks++; if (bus.count !== 5'd9) begin errors++; $display("FAIL refill_pre_count got=%0d exp=9", bus.count); end
    step(2'b11, 4'b1111, (UW*IW)'($urandom), 1'b1);
    checks++; if (bus.ready !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL refill_state got ready=%0b count=%0d exp ready=0 count=0", bus.ready, bus.count); end
    checks++; if (bus.underflow !== m_uf || bus.overflow !== m_of) begin errors++; $display("FAIL refill_flags got=%0b%0b exp=%0b%0b", bus.underflow, bus.overflow, m_uf, m_of); end
    repeat (4) step('0, '0, '0, 1'b0);
    checks++; if (bus.ready !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL refill_done got ready=%0b count=%0d exp ready=1 count=16", bus.ready, bus.count); end
    for (int c = 0; c < 8; c++) begin
      step(2'b11, '0, '0, 1'b0);
      checks++; if (obs_pd !== {4'(2*c+1), 4'(2*c)}) begin errors++; $display("FAIL refill_order c=%0d got=%0h exp=%0h", c, obs_pd, {4'(2*c+1), 4'(2*c)}); end
    end
  endtask

  task automatic test_random();
    logic rf;
    for (int c = 0; c < 300; c++) begin
      rf = ($urandom_range(0, 39) == 0);
      step(PW'($urandom), UW'($urandom), (UW*IW)'($urandom), rf);
      checks++; if ((obs_pd & exp_mask) !== exp_pd) begin errors++; $display("FAIL rand_pd c=%0d got=%0h exp=%0h", c, obs_pd & exp_mask, exp_pd); end
      checks++; if (bus.count !== 5'(q.size())) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, bus.count, q.size()); end
      checks++; if (bus.ready !== m_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%0b exp=%0b", c, bus.ready, m_ready); end
      checks++; if (bus.underflow !== m_uf || bus.overflow !== m_of) begin errors++; $display("FAIL rand_flags c=%0d got=%0b%0b exp=%0b%0b", c, bus.underflow, bus.overflow, m_uf, m_of); end
    end
  endtask

  task automatic test_rst_mid_init();
    step('0, '0, '0, 1'b1);
    repeat (2) step(2'b11, 4'b1111, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.ready !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL async_rst_state got ready=%0b count=%0d exp ready=0 count=0", bus.ready, bus.count); end
    checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL async_rst_flags got=%0b%0b exp=00", bus.underflow, bus.overflow); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step('0, '0, '0, 1'b0);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL restart_early_ready got=%0b exp=0", bus.ready); end
    step('0, '0, '0, 1'b0);
    checks++; if (bus.ready !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL restart_done got ready=%0b count=%0d exp ready=1 count=16", bus.ready, bus.count); end
    for (int c = 0; c < 8; c++) begin
      step(2'b11, '0, '0, 1'b0);
      checks++; if (obs_pd !== {4'(2*c+1), 4'(2*c)}) begin errors++; $display("FAIL restart_order c=%0d got=%0h exp=%0h", c, obs_pd, {4'(2*c+1), 4'(2*c)}); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_pop_pair();
    test_sparse_pop_overflow();
    test_underflow();
    test_wrap();
    test_refill();
    test_random();
    test_rst_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
